mux_serializer: RTL and testbench
=================================

MUX_SERIALIZER -- requirements
Module: mux_serializer

Interface
REQ-001 Parameter: MSB_FIRST, default 0, bit order (0: bit 0 first; 1: bit 7 first).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_data  input  8  parallel word to serialize.
REQ-005 Port: in_valid  input  1  in_data valid this cycle.
REQ-006 Port: in_ready  output  1  block can accept a word this cycle.
REQ-007 Port: sel  output  3  current bit index; drives the 8:1 mux select.
REQ-008 Port: ser_out  output  1  selected bit of the held word.
REQ-009 Port: ser_valid  output  1  ser_out carries a valid bit.
REQ-010 Port: ser_last  output  1  current bit is the final bit of the word.
REQ-011 Port: out_ready  input  1  downstream accepts the current bit this cycle.

Function
REQ-012 FSM states SHALL be IDLE and SHIFT only.
REQ-013 IDLE: in_ready=1, ser_valid=0, ser_last=0; a word is accepted when in_valid and in_ready are both 1 at a clock edge.
REQ-014 On acceptance: data_reg<=in_data, sel<=000 (MSB_FIRST=0) or 111 (MSB_FIRST=1), state<=SHIFT.
REQ-015 SHIFT: in_ready=0, ser_valid=1; in_valid is ignored and data_reg is held.
REQ-016 ser_out SHALL equal data_reg[sel] combinationally; first bit is valid in the cycle after acceptance (1-cycle latency).
REQ-017 A bit transfers when ser_valid and out_ready are both 1 at a clock edge; sel then steps +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1).
REQ-018 While out_ready=0 in SHIFT: sel, data_reg and ser_out SHALL hold unchanged.
REQ-019 ser_last=1 in SHIFT when sel=111 (MSB_FIRST=0) or sel=000 (MSB_FIRST=1).
REQ-020 Transfer with ser_last=1: state<=IDLE, sel<=start value; sel never wraps within a word.
REQ-021 Exactly 8 transfers per accepted word; minimum word period is 9 cycles (8 SHIFT + 1 IDLE).
REQ-022 In IDLE, sel SHALL rest at its start value, and ser_out SHALL still reflect data_reg[sel] (don't-care to consumers).

Reset
REQ-023 reset=1 at a clock edge SHALL force state=IDLE, data_reg=8'h00, and sel=start value, overriding any transfer or acceptance in the same cycle.
REQ-024 After reset: in_ready=1, ser_valid=0, ser_last=0, ser_out=0.
REQ-025 Reset asserted mid-word aborts the word; no further bits of it are emitted.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, SHIFT) and the constants WORD_W=8 and SEL_W=3.
REQ-027 Bit selection SHALL instantiate the existing mux8to1 sub-module (in=data_reg, sel=sel, out=ser_out); no other sub-modules.
REQ-028 Target size is 120-250 lines of RTL.

Verification
REQ-029 MSB_FIRST=0, load 8'b01010101, out_ready=1: ser_out=1,0,1,0,1,0,1,0 on sel=0..7; ser_last only at sel=7; in_ready back to 1 on the 9th cycle.
REQ-030 MSB_FIRST=1, load 8'hA5, out_ready=1: ser_out=1,0,1,0,0,1,0,1 on sel=7..0; ser_last only at sel=0.
REQ-031 Backpressure: load 8'h3C, drop out_ready for 4 cycles at sel=3: sel holds 3 and ser_out holds 1; the remaining bits resume correctly; 12 cycles from the first bit to return to IDLE.
REQ-032 Present in_valid=1 with 8'hFF during SHIFT of 8'h00: in_ready=0, ser_out stays 0 for all 8 bits, and 8'hFF is not accepted until IDLE.
REQ-033 Assert reset for 1 cycle at sel=5: next cycle state=IDLE, sel=0, ser_valid=0, in_ready=1; a fresh 8'h81 then serializes as 1,0,0,0,0,0,0,1.
REQ-034 Back-to-back 8'hFF then 8'h00 with in_valid held high: exactly one IDLE cycle between words; 16 transfers total with correct values.

Source files
------------

// File: rtl/mux_serializer_pkg.sv
// Shared types and constants for the 8-bit mux-based serializer.
package mux_serializer_pkg;

    localparam int WORD_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Select value at which a word starts: bit 0 for LSB-first, bit 7 for MSB-first.
    function automatic logic [SEL_W-1:0] start_sel(input int msb_first);
        return (msb_first != 0) ? SEL_W'(WORD_W - 1) : '0;
    endfunction

    // Select value of the final bit of a word, i.e. the opposite end from the start.
    function automatic logic [SEL_W-1:0] last_sel(input int msb_first);
        return (msb_first != 0) ? '0 : SEL_W'(WORD_W - 1);
    endfunction

endpackage

// File: rtl/mux_serializer_mux8to1.sv
// Plain 8:1 bit multiplexer: picks one bit of the held word by index.
module mux8to1
    import mux_serializer_pkg::*;
(
    input  logic [WORD_W-1:0] in,
    input  logic [SEL_W-1:0]  sel,
    output logic              out
);

    // Purely combinational bit pick; no storage in the mux itself.
    always_comb begin
        out = in[sel];
    end

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial converter: holds an accepted byte and walks an 8:1 mux
// select across it, one bit per downstream handshake.
module mux_serializer
    import mux_serializer_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SEL_W-1:0]  sel,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    input  logic              out_ready
);

    localparam logic [SEL_W-1:0] START_SEL = start_sel(MSB_FIRST);
    localparam logic [SEL_W-1:0] LAST_SEL  = last_sel(MSB_FIRST);

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] data_reg;
    logic              accept;
    logic              transfer;

    // State register; reset drops any word in flight back to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; IDLE only takes words, SHIFT only emits bits.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        ser_valid  = 1'b0;
        ser_last   = 1'b0;
        accept     = 1'b0;
        transfer   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_last  = (sel == LAST_SEL);
                transfer  = out_ready;
                if (out_ready && (sel == LAST_SEL)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Word capture; the byte stays put for the whole SHIFT phase and into IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg <= '0;
        end else if (accept) begin
            data_reg <= in_data;
        end
    end

    // Bit index walks toward the far end on each transfer and snaps back after the last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel <= START_SEL;
        end else if (accept) begin
            sel <= START_SEL;
        end else if (transfer) begin
            if (sel == LAST_SEL) begin
                sel <= START_SEL;
            end else if (MSB_FIRST != 0) begin
                sel <= sel - SEL_W'(1);
            end else begin
                sel <= sel + SEL_W'(1);
            end
        end
    end

    mux8to1 u_mux (
        .in  (data_reg),
        .sel (sel),
        .out (ser_out)
    );

endmodule

// File: tb/tb_mux_serializer.sv
// Self-checking bench: an LSB-first and an MSB-first serializer share one
// stimulus stream and are compared against a queue-based bit-stream model.
module tb_mux_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;

    logic       l_in_ready, l_ser_out, l_ser_valid, l_ser_last;
    logic [2:0] l_sel;
    logic       m_in_ready, m_ser_out, m_ser_valid, m_ser_last;
    logic [2:0] m_sel;

    int checks = 0;
    int errors = 0;

    // Model: outstanding bits of the current word in emission order, plus the last loaded byte.
    bit         q_l[$];
    bit         q_m[$];
    logic [7:0] last_word = 8'h00;

    always #5 clk = ~clk;

    mux_serializer #(.MSB_FIRST(0)) dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (l_in_ready),
        .sel       (l_sel),
        .ser_out   (l_ser_out),
        .ser_valid (l_ser_valid),
        .ser_last  (l_ser_last),
        .out_ready (out_ready)
    );

    mux_serializer #(.MSB_FIRST(1)) dut_msb (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (m_in_ready),
        .sel       (m_sel),
        .ser_out   (m_ser_out),
        .ser_valid (m_ser_valid),
        .ser_last  (m_ser_last),
        .out_ready (out_ready)
    );

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Compare every output of both instances with what the bit-stream model predicts.
    task automatic compareAll();
        bit         busy;
        int         done;
        logic [2:0] exp_l_sel;
        logic [2:0] exp_m_sel;
        busy      = (q_l.size() != 0);
        done      = busy ? 8 - q_l.size() : 0;
        exp_l_sel = 3'(done);
        exp_m_sel = 3'(7 - done);
        checkOutput("l_in_ready",  {7'b0, l_in_ready},  {7'b0, !busy});
        checkOutput("l_ser_valid", {7'b0, l_ser_valid}, {7'b0, busy});
        checkOutput("l_ser_last",  {7'b0, l_ser_last},  {7'b0, busy && q_l.size() == 1});
        checkOutput("l_sel",       {5'b0, l_sel},       {5'b0, exp_l_sel});
        checkOutput("l_ser_out",   {7'b0, l_ser_out},   {7'b0, busy ? q_l[0] : last_word[0]});
        checkOutput("m_in_ready",  {7'b0, m_in_ready},  {7'b0, !busy});
        checkOutput("m_ser_valid", {7'b0, m_ser_valid}, {7'b0, busy});
        checkOutput("m_ser_last",  {7'b0, m_ser_last},  {7'b0, busy && q_m.size() == 1});
        checkOutput("m_sel",       {5'b0, m_sel},       {5'b0, exp_m_sel});
        checkOutput("m_ser_out",   {7'b0, m_ser_out},   {7'b0, busy ? q_m[0] : last_word[7]});
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check outputs.
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d, input logic o);
        reset     = r;
        in_valid  = v;
        in_data   = d;
        out_ready = o;
        @(posedge clk);
        if (r) begin
            q_l.delete();
            q_m.delete();
            last_word = 8'h00;
        end else if (q_l.size() != 0) begin
            if (o) begin
                void'(q_l.pop_front());
                void'(q_m.pop_front());
            end
        end else if (v) begin
            for (int i = 0; i < 8; i++) begin
                q_l.push_back(d[i]);
                q_m.push_back(d[7 - i]);
            end
            last_word = d;
        end
        #1;
        compareAll();
    endtask

    task automatic sendWord(input logic [7:0] d);
        applyStimulus(1'b0, 1'b1, d, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        end
    endtask

    initial begin
        int count;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

        $display("[TB] full-rate words");
        sendWord(8'b01010101);
        sendWord(8'hA5);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

        $display("[TB] backpressure at bit 3");
        applyStimulus(1'b0, 1'b1, 8'h3C, 1'b1);
        count = 0;
        for (int i = 0; i < 30; i++) begin
            if (!l_ser_valid) break;
            count++;
            applyStimulus(1'b0, 1'b0, 8'h00, (count >= 4 && count <= 7) ? 1'b0 : 1'b1);
        end
        checkOutput("bp_cycles", 8'(count), 8'd12);

        $display("[TB] in_valid during SHIFT is ignored");
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

        $display("[TB] reset mid-word");
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        end
        checkOutput("pre_reset_sel", {5'b0, l_sel}, 8'd5);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        sendWord(8'h81);

        $display("[TB] back-to-back words");
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
        end
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                          1'($urandom_range(0, 1)),
                          8'($urandom),
                          ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
